// File: rtl/leaf_out_arbiter.sv
// Leaf-side output stage: round-robin arbitration of NUM_OUT_PORTS user streams into
// BFT packets, with per-port destination, wrapping address and credit flow control.
module leaf_out_arbiter #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 4,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    cfg_we,
    input  logic [3:0]                              cfg_idx,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dst_port,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    credit_upd_vld,
    input  logic [3:0]                              credit_upd_idx,
    input  logic                                    resend,
    input  logic                                    dout_ready,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    output logic [NUM_OUT_PORTS-1:0]                credit_zero
);

    // Handshakes: a user port keeps vld and data stable until it sees its ack pulse;
    // ack is high for exactly the cycle the payload is captured. The packet MSB is its
    // valid bit and it leaves the slot on a cycle with dout_ready=1 and resend=0.

    localparam int                    CREDIT_W     = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CREDIT_W-1:0]   CREDIT_MAX   = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
    localparam logic [31:0]           CREDIT_MAX32 = 32'(CREDIT_MAX);
    localparam logic [31:0]           UPD32        = 32'(FREESPACE_UPDATE_SIZE);

    logic [NUM_OUT_PORTS-1:0] cfg_vld_q, cfg_vld_d;
    logic [NUM_LEAF_BITS-1:0] dst_leaf_q [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dst_leaf_d [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dst_port_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dst_port_d [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_q     [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_d     [NUM_OUT_PORTS];
    logic [CREDIT_W-1:0]      credit_q   [NUM_OUT_PORTS];
    logic [CREDIT_W-1:0]      credit_d   [NUM_OUT_PORTS];
    logic [3:0]               rr_q, rr_d;
    logic [PACKET_BITS-1:0]   out_q, out_d;

    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] gnt_oh;
    logic                     gnt_found;
    logic [3:0]               gnt_idx;
    logic [PACKET_BITS-1:0]   gnt_pkt;
    logic                     out_valid;
    logic                     slot_free;
    logic                     grant_fire;
    logic [31:0]              credit_sum;

    assign out_valid  = out_q[PACKET_BITS-1];
    assign slot_free  = !out_valid || (dout_ready && !resend);
    assign grant_fire = slot_free && !resend && gnt_found;

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i]    = vld_user2interface[i] && cfg_vld_q[i] && (credit_q[i] != '0);
            credit_zero[i] = (credit_q[i] == '0);
        end
    end

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        gnt_oh    = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (!gnt_found && eligible[i] &&
                    (i == ((int'(rr_q) + k) % NUM_OUT_PORTS))) begin
                    gnt_oh[i] = 1'b1;
                    gnt_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        gnt_pkt = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt_oh[i]) begin
                gnt_idx = 4'(i);
                gnt_pkt = {1'b1, dst_leaf_q[i], dst_port_q[i], addr_q[i],
                           din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end
        end
    end

    assign ack_interface2user      = grant_fire ? gnt_oh : '0;
    assign dout_leaf_interface2bft = resend ? '0 : out_q;

    always_comb begin
        cfg_vld_d  = cfg_vld_q;
        dst_leaf_d = dst_leaf_q;
        dst_port_d = dst_port_q;
        addr_d     = addr_q;
        credit_d   = credit_q;
        credit_sum = '0;
        rr_d       = grant_fire ? gnt_idx : rr_q;

        out_d = out_q;
        if (grant_fire) begin
            out_d = gnt_pkt;
        end else if (out_valid && dout_ready && !resend) begin
            out_d = '0;
        end

        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            // Index compares only match real ports, so out-of-range indices fall through.
            if (cfg_we && (cfg_idx == 4'(i))) begin
                cfg_vld_d[i]  = 1'b1;
                dst_leaf_d[i] = cfg_dst_leaf;
                dst_port_d[i] = cfg_dst_port;
            end
            if (grant_fire && gnt_oh[i]) begin
                addr_d[i]   = addr_q[i] + NUM_ADDR_BITS'(1);
                credit_d[i] = credit_q[i] - CREDIT_W'(1);
            end
            if (credit_upd_vld && (credit_upd_idx == 4'(i))) begin
                credit_sum  = 32'(credit_d[i]) + UPD32;
                credit_d[i] = (credit_sum > CREDIT_MAX32) ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_vld_q <= '0;
            rr_q      <= '0;
            out_q     <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dst_leaf_q[i] <= '0;
                dst_port_q[i] <= '0;
                addr_q[i]     <= '0;
                credit_q[i]   <= CREDIT_MAX;
            end
        end else begin
            cfg_vld_q  <= cfg_vld_d;
            rr_q       <= rr_d;
            out_q      <= out_d;
            dst_leaf_q <= dst_leaf_d;
            dst_port_q <= dst_port_d;
            addr_q     <= addr_d;
            credit_q   <= credit_d;
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue/array based behavioural model.
module tb_leaf_out_arbiter;

    localparam int PB   = 49;
    localparam int PL   = 32;
    localparam int N    = 4;
    localparam int CMAX = 128;
    localparam int UPD  = 64;

    logic            clk;
    logic            reset_n;
    logic            cfg_we;
    logic [3:0]      cfg_idx;
    logic [4:0]      cfg_dst_leaf;
    logic [3:0]      cfg_dst_port;
    logic [N*PL-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic            credit_upd_vld;
    logic [3:0]      credit_upd_idx;
    logic            resend;
    logic            dout_ready;
    logic [PB-1:0]   dout;
    logic [N-1:0]    cz;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cfg_we                  (cfg_we),
        .cfg_idx                 (cfg_idx),
        .cfg_dst_leaf            (cfg_dst_leaf),
        .cfg_dst_port            (cfg_dst_port),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .credit_upd_vld          (credit_upd_vld),
        .credit_upd_idx          (credit_upd_idx),
        .resend                  (resend),
        .dout_ready              (dout_ready),
        .dout_leaf_interface2bft (dout),
        .credit_zero             (cz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // model state
    int            m_credit [N];
    int            m_addr   [N];
    logic          m_cfg    [N];
    logic [4:0]    m_leaf   [N];
    logic [3:0]    m_port   [N];
    int            m_rr;
    logic [PB-1:0] m_out;
    logic [PB-1:0] exp_q [$];
    logic [PB-1:0] acc_q [$];
    int            gnt_log [$];
    int            gnt_cyc [$];
    int            cyc;

    // user side
    int          want [N];
    int          sent [N];
    logic [31:0] pay  [N];
    logic [N-1:0] ack_s;

    always_comb begin
        for (int i = 0; i < N; i++) din[i*PL +: PL] = pay[i];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_credit[i] = CMAX;
            m_addr[i]   = 0;
            m_cfg[i]    = 1'b0;
            m_leaf[i]   = '0;
            m_port[i]   = '0;
        end
        m_rr  = 0;
        m_out = '0;
        exp_q.delete();
    endtask

    int            c_g;
    int            c_j;
    int            c_ui;
    logic          c_free;
    logic [N-1:0]  c_ack;
    logic [N-1:0]  c_cz;
    logic [PB-1:0] c_dout;
    logic [PB-1:0] c_pkt;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) model_reset();
        c_free = !m_out[PB-1] || (dout_ready && !resend);
        c_g = -1;
        if (c_free && !resend) begin
            for (int k = 1; k <= N; k++) begin
                c_j = (m_rr + k) % N;
                if (c_g < 0 && vld[c_j] && m_cfg[c_j] && m_credit[c_j] > 0) c_g = c_j;
            end
        end
        c_ack = '0;
        if (c_g >= 0) c_ack[c_g] = 1'b1;
        c_dout = resend ? '0 : m_out;
        for (int i = 0; i < N; i++) c_cz[i] = (m_credit[i] == 0);
        check("ack", 64'(ack), 64'(c_ack));
        check("dout", 64'(dout), 64'(c_dout));
        check("credit_zero", 64'(cz), 64'(c_cz));
        ack_s = ack;
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                gnt_log.push_back(i);
                gnt_cyc.push_back(cyc);
            end
        end
        if (reset_n && dout[PB-1] && dout_ready && !resend) begin
            acc_q.push_back(dout);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got=%0h expected=none", dout);
            end else begin
                check("sb_pkt", 64'(dout), 64'(exp_q.pop_front()));
            end
        end
        if (reset_n) begin
            if (c_g >= 0) begin
                c_pkt = {1'b1, m_leaf[c_g], m_port[c_g], 7'(m_addr[c_g]), din[c_g*PL +: PL]};
                m_out = c_pkt;
                exp_q.push_back(c_pkt);
                m_addr[c_g]   = (m_addr[c_g] + 1) % 128;
                m_credit[c_g] = m_credit[c_g] - 1;
                m_rr          = c_g;
            end else if (m_out[PB-1] && dout_ready && !resend) begin
                m_out = '0;
            end
            c_ui = int'(credit_upd_idx);
            if (credit_upd_vld && c_ui < N)
                m_credit[c_ui] = (m_credit[c_ui] + UPD > CMAX) ? CMAX : m_credit[c_ui] + UPD;
            c_ui = int'(cfg_idx);
            if (cfg_we && c_ui < N) begin
                m_cfg[c_ui]  = 1'b1;
                m_leaf[c_ui] = cfg_dst_leaf;
                m_port[c_ui] = cfg_dst_port;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (vld[i] && ack_s[i]) begin
                sent[i]++;
                if (want[i] > 0) want[i]--;
                pay[i] = $urandom;
            end
            vld[i] = (want[i] > 0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_want(input int i, input int n);
        want[i] = n;
        vld[i]  = (n > 0);
    endtask

    task automatic cfg_write(input int idx, input int leaf, input int port);
        cfg_we       = 1'b1;
        cfg_idx      = 4'(idx);
        cfg_dst_leaf = 5'(leaf);
        cfg_dst_port = 4'(port);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_credit_zero", 64'(cz), 64'd0);
        for (int i = 0; i < N; i++) begin
            want[i] = 0;
            sent[i] = 0;
            vld[i]  = 1'b0;
        end
        step();
        step();
        reset_n = 1'b1;
    endtask

    logic [PB-1:0] t_exp;
    logic [PB-1:0] t_p;
    logic [31:0]   p1;
    int            hits;
    int            exp_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        total = 0; bad = 0; cyc = 0;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_dst_leaf = '0; cfg_dst_port = '0;
        vld = '0; credit_upd_vld = 1'b0; credit_upd_idx = '0; resend = 1'b0; dout_ready = 1'b1;
        ack_s = '0;
        for (int i = 0; i < N; i++) begin
            pay[i] = '0; want[i] = 0; sent[i] = 0;
        end
        do_reset();

        // 1: single packet from port0
        cfg_write(0, 3, 2);
        pay[0] = 32'hDEADBEEF;
        set_want(0, 1);
        @(negedge clk);
        check("t1_ack", 64'(ack), 64'(4'b0001));
        step();
        @(negedge clk);
        t_exp = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
        check("t1_dout", 64'(dout), 64'(t_exp));

        // 2: all four ports request, round-robin order
        cfg_write(1, 1, 1);
        cfg_write(2, 2, 3);
        cfg_write(3, 4, 4);
        gnt_log.delete();
        gnt_cyc.delete();
        for (int i = 0; i < N; i++) set_want(i, 8);
        run(40);
        check("t2_grants", 64'(gnt_log.size()), 64'd32);
        if (gnt_log.size() >= 32) begin
            for (int k = 0; k < 8; k++) check("t2_order", 64'(gnt_log[k]), 64'(exp_order[k]));
            check("t2_rate", 64'(gnt_cyc[31] - gnt_cyc[0]), 64'd31);
        end

        // 3: credit exhaustion and a single refill
        do_reset();
        cfg_write(0, 1, 1);
        set_want(0, 130);
        run(200);
        check("t3_sent128", 64'(sent[0]), 64'd128);
        @(negedge clk);
        check("t3_cz", 64'(cz[0]), 64'd1);
        check("t3_stall", 64'(ack[0]), 64'd0);
        set_want(0, want[0] + 100);
        credit_upd_vld = 1'b1;
        credit_upd_idx = 4'd0;
        step();
        credit_upd_vld = 1'b0;
        run(100);
        check("t3_sent192", 64'(sent[0]), 64'd192);
        @(negedge clk);
        check("t3_cz2", 64'(cz[0]), 64'd1);
        set_want(0, 0);
        credit_upd_vld = 1'b1;
        run(2);
        credit_upd_vld = 1'b0;

        // 4: address wrap on port1 under random credit refresh and backpressure
        cfg_write(1, 7, 5);
        acc_q.delete();
        set_want(1, 200);
        for (int c = 0; c < 3000 && sent[1] < 200; c++) begin
            step();
            credit_upd_vld = ($urandom_range(0, 3) == 0);
            credit_upd_idx = 4'($urandom_range(0, 5));
            dout_ready     = ($urandom_range(0, 3) != 0);
        end
        check("t4_sent", 64'(sent[1]), 64'd200);
        credit_upd_vld = 1'b1;
        credit_upd_idx = 4'd1;
        dout_ready     = 1'b1;
        run(3);
        credit_upd_vld = 1'b0;
        check("t4_accepted", 64'(acc_q.size()), 64'd200);
        if (acc_q.size() >= 129) begin
            t_p = acc_q[127];
            check("t4_addr127", 64'(t_p[38:32]), 64'd127);
            t_p = acc_q[128];
            check("t4_addr_wrap", 64'(t_p[38:32]), 64'd0);
        end

        // 5: held packet survives resend
        acc_q.delete();
        dout_ready = 1'b0;
        set_want(1, 1);
        p1 = pay[1];
        @(negedge clk);
        check("t5_ack", 64'(ack), 64'(4'b0010));
        step();
        step();
        t_exp = {1'b1, 5'd7, 4'd5, 7'd72, p1};
        @(negedge clk);
        check("t5_held", 64'(dout), 64'(t_exp));
        step();
        resend     = 1'b1;
        dout_ready = 1'b1;
        set_want(0, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_rs_dout", 64'(dout), 64'd0);
            check("t5_rs_ack", 64'(ack), 64'd0);
            step();
        end
        resend     = 1'b0;
        dout_ready = 1'b0;
        @(negedge clk);
        check("t5_back", 64'(dout), 64'(t_exp));
        step();
        dout_ready = 1'b1;
        run(2);
        set_want(0, 0);
        step();
        hits = 0;
        foreach (acc_q[k]) if (acc_q[k] == t_exp) hits++;
        check("t5_once", 64'(hits), 64'd1);

        // 6: unconfigured port, grant+update at full credit, reset mid-stream
        do_reset();
        cfg_write(0, 2, 2);
        set_want(2, 5);
        run(20);
        check("t6_unconf", 64'(sent[2]), 64'd0);
        set_want(2, 0);
        set_want(0, 200);
        credit_upd_vld = 1'b1;
        credit_upd_idx = 4'd0;
        @(negedge clk);
        check("t6_ack_upd", 64'(ack), 64'(4'b0001));
        step();
        credit_upd_vld = 1'b0;
        run(200);
        check("t6_sat", 64'(sent[0]), 64'd129);
        credit_upd_vld = 1'b1;
        step();
        credit_upd_vld = 1'b0;
        run(3);
        do_reset();
        cfg_write(0, 2, 2);
        set_want(0, 130);
        run(200);
        check("t6_credit_back", 64'(sent[0]), 64'd128);
        set_want(0, 0);

        // random traffic
        cfg_write(1, 9, 1);
        cfg_write(2, 10, 2);
        cfg_write(3, 11, 3);
        for (int c = 0; c < 1500; c++) begin
            step();
            dout_ready     = ($urandom_range(0, 3) != 0);
            resend         = ($urandom_range(0, 19) == 0);
            credit_upd_vld = ($urandom_range(0, 3) == 0);
            credit_upd_idx = 4'($urandom_range(0, 5));
            cfg_we         = ($urandom_range(0, 15) == 0);
            cfg_idx        = 4'($urandom_range(0, 5));
            cfg_dst_leaf   = 5'($urandom);
            cfg_dst_port   = 4'($urandom);
            for (int i = 0; i < N; i++)
                if (want[i] == 0 && $urandom_range(0, 3) == 0) set_want(i, $urandom_range(1, 6));
        end
        step();
        resend = 1'b0; cfg_we = 1'b0; credit_upd_vld = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < N; i++) set_want(i, 0);
        run(5);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
